qq_dequeue_reader: RTL and testbench
====================================

# qq_dequeue_reader

Dequeue-side reader for the quickQueueTop priority queue. On a `start` command it removes up to `count` entries from the queue head, one at a time. Each removed key goes out on a valid/ready output stream in priority order (smallest first). The block sits between quickQueueTop and any downstream consumer, and it is the counterpart to the enqueue traffic the queue receives. It never issues a dequeue while the queue is busy reordering, while the queue is empty, or while its own output register is still occupied.

## Interface
- `DATA_W`, 32, key width; must match quickQueueTop data width.
- `CNT_W`, 16, width of `count` and `drained`.
- `SETTLE`, 2, minimum cycles after a `q_deq` pulse before `q_busy` is trusted.
- `TIMEOUT`, 64, maximum cycles `q_busy` may stay high in WAIT (only used with `QQ_READER_TIMEOUT_EN`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `count`  in  CNT_W  number of entries to drain; latched on an accepted `start`.
- `q_data`  in  DATA_W  current queue head key (quickQueueTop head output).
- `q_empty`  in  1  queue holds no entries.
- `q_busy`  in  1  queue is swapping/reordering; head not yet stable.
- `q_deq`  out  1  one-cycle dequeue pulse to the queue.
- `out_data`  out  DATA_W  dequeued key.
- `out_valid`  out  1  `out_data` holds an unconsumed key.
- `out_ready`  in  1  downstream accepts; a transfer occurs when `out_valid && out_ready`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when a command completes or aborts.
- `drained`  out  CNT_W  keys dequeued by the current/last command.
- `underflow`  out  1  the queue emptied before `count` was reached; sticky until next accepted `start`.
- `timeout`  out  1  `q_busy` stayed high past TIMEOUT; sticky until next accepted `start`.

## Operation
- FSM states: IDLE, CHECK, WAIT.
- IDLE:
  - `start && count != 0` → latch `remaining = count`, clear `drained`/`underflow`/`timeout`, go to CHECK.
  - `start && count == 0` → `done` pulse; no other state change; stay IDLE.
  - `start` outside IDLE is ignored.
- CHECK, evaluated in priority order:
  1. `q_empty` → set `underflow`, `done` pulse, go to IDLE.
  2. `q_busy`, or `out_valid && !out_ready` → stay in CHECK.
  3. Otherwise → capture `q_data` into `out_data`, set `out_valid`, assert `q_deq`, increment `drained`, decrement `remaining`, go to WAIT.
- WAIT:
  - Settle counter runs SETTLE cycles, then the block waits for `q_busy == 0`.
  - On exit: `remaining == 0` → `done` pulse, go to IDLE; otherwise go to CHECK.
- Output register:
  - `out_valid` clears on a transfer unless a new capture happens in the same cycle.
  - Capture when `out_valid && out_ready` in the same cycle is legal: data is replaced and `out_valid` stays 1.
- `drained` saturates at 2^CNT_W−1. `remaining` never underflows, because `count == 0` is rejected in IDLE.
- Reset mid-operation:
  - All outputs return to reset values and the FSM goes to IDLE.
  - An in-flight key in `out_data` is discarded.
  - The queue itself is not touched.

## Timing
- Reset values: `q_deq`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `drained`=0, `underflow`=0, `timeout`=0.
- All outputs are registered.
- `start` accepted at edge N → `busy`=1 from N.
- First possible `q_deq` after edge N+1, i.e. one CHECK cycle.
- Each CHECK exit pulses `q_deq` high for exactly one cycle. In the same cycle `out_valid` rises and `out_data` holds the pre-dequeue head.
- Minimum spacing between `q_deq` pulses: SETTLE+2 cycles (one pulse per SETTLE+2 cycles at full rate, with `q_busy` low and `out_ready` high).
- `done` rises in the cycle after the final WAIT exit (or CHECK underflow exit) and coincides with `busy` falling.

## Configuration
- `QQ_READER_TIMEOUT_EN` defined:
  - A TIMEOUT counter runs in WAIT while `q_busy` is high.
  - On reaching TIMEOUT the block sets `timeout`, pulses `done`, and goes to IDLE without further dequeues.
- Not defined:
  - No counter is built and `timeout` is tied to 0.
  - WAIT waits for `q_busy` indefinitely.

## Test plan
- Queue model preloaded {2,3,4,9}, `count`=2, `out_ready`=1 → keys 2 then 3 on the output; `done` pulses; `drained`=2; `underflow`=0; 2 `q_deq` pulses; model holds {4,9}.
- Empty queue, `count`=3 → no `q_deq`; `underflow`=1; `done` pulses within 2 cycles; `drained`=0.
- Queue {4,9}, `count`=5 → keys 4, 9 out; then `underflow`=1; `drained`=2; `done`=1.
- `out_ready`=0 for 10 cycles after the first key, queue {2,3} → `out_data` holds 2 for 10 cycles; second `q_deq` only after `out_ready` rises; no key lost or duplicated.
- `q_busy` held high 100 cycles after the first `q_deq`:
  - with `QQ_READER_TIMEOUT_EN` and TIMEOUT=64 → `timeout`=1 and `done` after 64 WAIT cycles;
  - without the macro → the block stays in WAIT until `q_busy` drops.
- `rst` asserted between two `q_deq` pulses of a `count`=4 drain → all outputs at reset values asynchronously; `start` after reset release begins a fresh command.

Source files
------------

// File: rtl/qq_dequeue_reader_if.sv
// -----------------------------------------------------------------------------
// qq_dequeue_reader_if
//
// Purpose: bundles the two data-path faces of the dequeue reader into one
// interface: the quickQueueTop head/dequeue signals and the valid/ready key
// output stream.
//
// Signals:
//   q_data    head key presented by the queue
//   q_empty   queue holds no entries
//   q_busy    queue is reordering, head not yet stable
//   q_deq     one-cycle dequeue pulse toward the queue
//   out_data  dequeued key toward the consumer
//   out_valid out_data holds an unconsumed key
//   out_ready consumer accepts the key this cycle
//
// Modports:
//   master  the reader (drives q_deq and the output stream)
//   slave   the environment (queue plus downstream consumer)
// -----------------------------------------------------------------------------
interface qq_dequeue_reader_if #(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] q_data;
   logic              q_empty;
   logic              q_busy;
   logic              q_deq;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      input  q_data,
      input  q_empty,
      input  q_busy,
      output q_deq,
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      output q_data,
      output q_empty,
      output q_busy,
      input  q_deq,
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/qq_dequeue_reader.sv
// -----------------------------------------------------------------------------
// qq_dequeue_reader
//
// Purpose: on a start command, removes up to `count` keys from the head of a
// quickQueueTop priority queue, one at a time, and forwards each key on a
// valid/ready stream (smallest key first, as the queue orders them). A dequeue
// is never issued while the queue is busy, empty, or while the output register
// still holds an unconsumed key.
//
// Parameters:
//   DATA_W   key width (must match the queue)
//   CNT_W    width of count / drained
//   SETTLE   cycles after a q_deq pulse before q_busy is trusted
//   TIMEOUT  max q_busy-high cycles tolerated in WAIT (timeout build only)
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      command strobe (only looked at in IDLE)
//   count      number of keys to drain, latched on an accepted start
//   qif        qq_dequeue_reader_if.master: queue head + output stream
//   busy       FSM is not in IDLE
//   done       one-cycle pulse when a command completes or aborts
//   drained    keys dequeued by the current/last command (saturating)
//   underflow  queue ran empty before count was reached (sticky)
//   timeout    q_busy stuck high in WAIT (sticky, timeout build only)
//
// Build option: define QQ_READER_TIMEOUT_EN to build the WAIT watchdog.
// Without it, timeout is tied low and WAIT waits for q_busy indefinitely.
// -----------------------------------------------------------------------------
module qq_dequeue_reader #(
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 16,
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_W-1:0]     count,
   qq_dequeue_reader_if.master  qif,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     drained,
   output logic                 underflow,
   output logic                 timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam int SET_W = ($clog2(SETTLE + 1) < 1) ? 1 : $clog2(SETTLE + 1);
   localparam logic [SET_W-1:0] SETTLE_LD = SETTLE[SET_W-1:0];
   localparam logic [SET_W-1:0] SET_ONE   = {{(SET_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t state_reg, state_next;

   logic [CNT_W-1:0]  remaining_reg, remaining_next;
   logic [CNT_W-1:0]  drained_reg,   drained_next;
   logic [SET_W-1:0]  settle_reg,    settle_next;
   logic [DATA_W-1:0] out_data_reg,  out_data_next;
   logic              out_valid_reg, out_valid_next;
   logic              q_deq_reg,     q_deq_next;
   logic              done_reg,      done_next;
   logic              underflow_reg, underflow_next;
   logic              busy_reg,      busy_next;

   // Decoded events of the current cycle
   logic accept;     // non-zero command accepted in IDLE
   logic zero_cmd;   // count == 0 command: done pulse only
   logic underrun;   // CHECK found the queue empty
   logic take;       // CHECK captures the head and dequeues it
   logic wait_exit;  // settle time over and queue stable
   logic abort;      // watchdog expiry in WAIT

   assign accept    = (state_reg == IDLE) && start && (count != '0);
   assign zero_cmd  = (state_reg == IDLE) && start && (count == '0);
   assign underrun  = (state_reg == CHECK) && qif.q_empty;
   // Output register must be free or emptying this very cycle before a new
   // key may be captured, so no key is ever overwritten unconsumed.
   assign take      = (state_reg == CHECK) && !qif.q_empty && !qif.q_busy &&
                      !(out_valid_reg && !qif.out_ready);
   assign wait_exit = (state_reg == WAIT) && (settle_reg == '0) && !qif.q_busy;

`ifdef QQ_READER_TIMEOUT_EN
   localparam int TO_W = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

   logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
   logic            timeout_reg, timeout_next;

   // Counts every WAIT cycle with q_busy high (settle phase included); the
   // TIMEOUT-th such cycle aborts the command.
   assign abort = (state_reg == WAIT) && qif.q_busy && (to_cnt_reg == TO_LAST);

   always_comb begin
      to_cnt_next  = to_cnt_reg;
      timeout_next = timeout_reg;
      if (accept)
         timeout_next = 1'b0;
      if (abort)
         timeout_next = 1'b1;
      if (take)
         to_cnt_next = '0;
      else if ((state_reg == WAIT) && qif.q_busy && !abort)
         to_cnt_next = to_cnt_reg + TO_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_reg  <= '0;
         timeout_reg <= 1'b0;
      end else begin
         to_cnt_reg  <= to_cnt_next;
         timeout_reg <= timeout_next;
      end
   end

   assign timeout = timeout_reg;
`else
   logic to_unused;
   assign to_unused = TIMEOUT[0];
   assign abort     = 1'b0;
   assign timeout   = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept)
               state_next = CHECK;
         end
         CHECK: begin
            if (qif.q_empty)
               state_next = IDLE;
            else if (take)
               state_next = WAIT;
         end
         WAIT: begin
            if (abort)
               state_next = IDLE;
            else if (wait_exit)
               state_next = (remaining_reg == '0) ? IDLE : CHECK;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: output / datapath next values (all outputs are registered)
   // ---------------------------------------------------------------------
   always_comb begin
      remaining_next = remaining_reg;
      drained_next   = drained_reg;
      settle_next    = settle_reg;
      out_data_next  = out_data_reg;
      out_valid_next = out_valid_reg;
      underflow_next = underflow_reg;
      q_deq_next     = take;
      busy_next      = (state_next != IDLE);
      done_next      = zero_cmd || underrun || abort ||
                       (wait_exit && (remaining_reg == '0));

      if (accept) begin
         remaining_next = count;
         drained_next   = '0;
         underflow_next = 1'b0;
      end

      if (underrun)
         underflow_next = 1'b1;

      // A transfer empties the register; a same-cycle capture refills it.
      if (out_valid_reg && qif.out_ready)
         out_valid_next = 1'b0;

      if (take) begin
         out_data_next  = qif.q_data;
         out_valid_next = 1'b1;
         remaining_next = remaining_reg - CNT_ONE;
         settle_next    = SETTLE_LD;
         if (drained_reg != CNT_MAX)
            drained_next = drained_reg + CNT_ONE;
      end else if ((state_reg == WAIT) && (settle_reg != '0)) begin
         settle_next = settle_reg - SET_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining_reg <= '0;
         drained_reg   <= '0;
         settle_reg    <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         q_deq_reg     <= 1'b0;
         done_reg      <= 1'b0;
         underflow_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         remaining_reg <= remaining_next;
         drained_reg   <= drained_next;
         settle_reg    <= settle_next;
         out_data_reg  <= out_data_next;
         out_valid_reg <= out_valid_next;
         q_deq_reg     <= q_deq_next;
         done_reg      <= done_next;
         underflow_reg <= underflow_next;
         busy_reg      <= busy_next;
      end
   end

   assign qif.q_deq     = q_deq_reg;
   assign qif.out_data  = out_data_reg;
   assign qif.out_valid = out_valid_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;
   assign drained       = drained_reg;
   assign underflow     = underflow_reg;

endmodule

// File: tb/tb_qq_dequeue_reader.sv
`timescale 1ns/1ps
module tb_qq_dequeue_reader;
   localparam int DATA_W  = 32;
   localparam int CNT_W   = 16;
   localparam int SETTLE  = 2;
   localparam int TIMEOUT = 64;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] count;
   logic             busy, done, underflow, timeout;
   logic [CNT_W-1:0] drained;

   qq_dequeue_reader_if #(.DATA_W(DATA_W)) qif();

   qq_dequeue_reader #(
      .DATA_W(DATA_W), .CNT_W(CNT_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .count(count), .qif(qif),
      .busy(busy), .done(done), .drained(drained),
      .underflow(underflow), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // ---------------- queue model (sorted keys pushed in order) -----------
   logic [DATA_W-1:0] mem [0:15];
   logic [3:0]        hd, tl;
   int                mcnt;
   logic              busy_pulse = 1'b0;
   logic              hold_busy, push_en, clr_en;
   logic [DATA_W-1:0] push_key;
   int                bad_deq = 0;
   logic              pop;

   assign pop         = qif.q_deq && (mcnt != 0);
   assign qif.q_data  = (mcnt == 0) ? '0 : mem[hd];
   assign qif.q_empty = (mcnt == 0);
   assign qif.q_busy  = busy_pulse | hold_busy;

   always @(posedge clk) begin
      busy_pulse <= qif.q_deq;   // queue reorders for one cycle after a dequeue
      if (qif.q_deq && (mcnt == 0))
         bad_deq <= bad_deq + 1;
      if (clr_en) begin
         hd <= '0; tl <= '0; mcnt <= 0;
      end else begin
         if (push_en) begin
            mem[tl] <= push_key;
            tl      <= tl + 4'd1;
         end
         if (pop)
            hd <= hd + 4'd1;
         mcnt <= mcnt + (push_en ? 1 : 0) - (pop ? 1 : 0);
      end
   end

   // ---------------- scoreboard / bookkeeping ----------------------------
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] exp_key;
   int vec_cnt = 0, err_cnt = 0, cyc = 0;
   int deq_cnt = 0, deq_first = 0, deq_last = 0, done_cnt = 0, done_cyc = 0;
   logic busy_at_done;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vec_cnt++;
      assert (obs === expv) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One clock: sample at negedge, return 1 ns after the rising edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (qif.out_valid && qif.out_ready) begin
         check("key_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            exp_key = exp_q.pop_front();
            check("key", 64'(qif.out_data), 64'(exp_key));
            $display("cycle %0d: key %0d out", cyc, qif.out_data);
         end
      end
      if (qif.q_deq) begin
         deq_cnt++;
         if (deq_cnt == 1) deq_first = cyc;
         deq_last = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = busy;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] key);
      push_en = 1'b1; push_key = key;
      tick();
      push_en = 1'b0;
   endtask

   task automatic start_cmd(input int n);
      deq_cnt = 0; done_cnt = 0;
      start = 1'b1; count = CNT_W'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      for (int i = 0; i < max && done_cnt == 0; i++) tick();
      check(tag, 64'(done_cnt != 0), 64'd1);
   endtask

   task automatic wait_deq(input string tag, input int max);
      for (int i = 0; i < max && deq_cnt == 0; i++) tick();
      check(tag, 64'(deq_cnt != 0), 64'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; count = '0; qif.out_ready = 1'b1;
      hold_busy = 1'b0; push_en = 1'b0; push_key = '0; clr_en = 1'b1;
      repeat (3) tick();
      check("rst_q_deq",     64'(qif.q_deq), 64'd0);
      check("rst_out_valid", 64'(qif.out_valid), 64'd0);
      check("rst_out_data",  64'(qif.out_data), 64'd0);
      check("rst_busy",      64'(busy), 64'd0);
      check("rst_done",      64'(done), 64'd0);
      check("rst_drained",   64'(drained), 64'd0);
      check("rst_underflow", 64'(underflow), 64'd0);
      check("rst_timeout",   64'(timeout), 64'd0);
      clr_en = 1'b0; rst = 1'b0;
      tick();

      // count == 0: done pulse only
      start_cmd(0);
      check("zero_done", 64'(done), 64'd1);
      check("zero_busy", 64'(busy), 64'd0);
      tick();
      check("zero_done_fall", 64'(done), 64'd0);

      // queue {2,3,4,9}, drain 2
      push(2); push(3); push(4); push(9);
      exp_q.push_back(2); exp_q.push_back(3);
      start_cmd(2);
      check("t1_busy_rise", 64'(busy), 64'd1);
      check("t1_no_deq_in_check", 64'(qif.q_deq), 64'd0);
      tick();
      check("t1_first_deq",   64'(qif.q_deq), 64'd1);
      check("t1_valid_rise",  64'(qif.out_valid), 64'd1);
      check("t1_head_data",   64'(qif.out_data), 64'd2);
      wait_done("t1_done", 60);
      check("t1_busy_at_done", 64'(busy_at_done), 64'd0);
      check("t1_drained",   64'(drained), 64'd2);
      check("t1_underflow", 64'(underflow), 64'd0);
      check("t1_deq_cnt",   64'(deq_cnt), 64'd2);
      check("t1_spacing",   64'(deq_last - deq_first), 64'(SETTLE + 2));
      check("t1_model_cnt", 64'(mcnt), 64'd2);
      check("t1_model_head", 64'(qif.q_data), 64'd4);
      check("t1_sb_empty",  64'(exp_q.size()), 64'd0);

      // queue {4,9}, drain 5 -> underflow after two keys
      exp_q.push_back(4); exp_q.push_back(9);
      start_cmd(5);
      wait_done("t3_done", 80);
      check("t3_drained",   64'(drained), 64'd2);
      check("t3_underflow", 64'(underflow), 64'd1);
      check("t3_deq_cnt",   64'(deq_cnt), 64'd2);
      check("t3_model_cnt", 64'(mcnt), 64'd0);
      check("t3_sb_empty",  64'(exp_q.size()), 64'd0);

      // empty queue, drain 3
      start_cmd(3);
      wait_done("t2_done_2cyc", 2);
      check("t2_deq_cnt",   64'(deq_cnt), 64'd0);
      check("t2_underflow", 64'(underflow), 64'd1);
      check("t2_drained",   64'(drained), 64'd0);

      // back-pressure: out_ready low for 10 cycles after the first key
      push(2); push(3);
      exp_q.push_back(2); exp_q.push_back(3);
      qif.out_ready = 1'b0;
      start_cmd(2);
      wait_deq("t4_first_deq", 10);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4_hold_valid", 64'(qif.out_valid), 64'd1);
         check("t4_hold_data",  64'(qif.out_data), 64'd2);
      end
      check("t4_no_second_deq", 64'(deq_cnt), 64'd1);
      qif.out_ready = 1'b1;
      wait_done("t4_done", 60);
      check("t4_deq_cnt",  64'(deq_cnt), 64'd2);
      check("t4_drained",  64'(drained), 64'd2);
      check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

      // q_busy stuck high after the first dequeue
      push(5); push(6);
      exp_q.push_back(5);
      start_cmd(2);
      wait_deq("t5_first_deq", 10);
      hold_busy = 1'b1;
`ifdef QQ_READER_TIMEOUT_EN
      wait_done("t5_timeout_done", 120);
      check("t5_timeout",  64'(timeout), 64'd1);
      check("t5_deq_cnt",  64'(deq_cnt), 64'd1);
      check("t5_drained",  64'(drained), 64'd1);
      // First WAIT cycle sees q_busy low in this model, then TIMEOUT busy cycles.
      check("t5_to_latency", 64'(done_cyc - deq_first), 64'(TIMEOUT + 1));
      check("t5_model_cnt", 64'(mcnt), 64'd1);
      hold_busy = 1'b0;
      clr_en = 1'b1; tick(); clr_en = 1'b0;
`else
      repeat (100) tick();
      check("t5_still_busy", 64'(busy), 64'd1);
      check("t5_no_done",    64'(done_cnt), 64'd0);
      check("t5_deq_cnt",    64'(deq_cnt), 64'd1);
      check("t5_timeout",    64'(timeout), 64'd0);
      exp_q.push_back(6);
      hold_busy = 1'b0;
      wait_done("t5_done", 60);
      check("t5_drained",   64'(drained), 64'd2);
      check("t5_deq_total", 64'(deq_cnt), 64'd2);
      check("t5_model_cnt", 64'(mcnt), 64'd0);
`endif
      check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

      // asynchronous reset in the middle of a count=4 drain
      push(1); push(2); push(3); push(4);
      exp_q.push_back(1);
      start_cmd(4);
      wait_deq("t6_first_deq", 10);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_busy",      64'(busy), 64'd0);
      check("t6_rst_valid",     64'(qif.out_valid), 64'd0);
      check("t6_rst_data",      64'(qif.out_data), 64'd0);
      check("t6_rst_drained",   64'(drained), 64'd0);
      check("t6_rst_q_deq",     64'(qif.q_deq), 64'd0);
      check("t6_rst_underflow", 64'(underflow), 64'd0);
      tick(); tick();
      rst = 1'b0;
      tick();
      check("t6_model_kept", 64'(mcnt), 64'd3);
      exp_q.push_back(2);
      start_cmd(1);
      wait_done("t6_fresh_done", 40);
      check("t6_fresh_drained", 64'(drained), 64'd1);
      check("t6_fresh_deq",     64'(deq_cnt), 64'd1);
      check("t6_model_cnt",     64'(mcnt), 64'd2);
      check("t6_sb_empty",      64'(exp_q.size()), 64'd0);

      check("no_deq_on_empty", 64'(bad_deq), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
